// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative HI/LO multiply/divide unit.
// Operation codes match the op port; the low bit marks the signed variants.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } state_t;

  function automatic logic op_is_signed(input op_t o);
    return o[0];
  endfunction

  function automatic logic op_is_div(input op_t o);
    return o[1];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: used to take magnitudes at capture
// and to restore signs on the product, quotient and remainder.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding HI/LO: one bit per clock on operand
// magnitudes, followed by a single sign-correction cycle that writes HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state_reg, state_next;
  op_t                op_reg;
  logic               neg_q_reg, neg_r_reg;
  logic [CNT_W-1:0]   counter_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               busy_reg, done_reg;

  // Capture-side decode and operand magnitudes
  op_t              op_in;
  logic             sgn_in, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign op_in  = op_t'(op);
  assign sgn_in = op_is_signed(op_in);
  assign a_neg  = sgn_in & busA[WIDTH-1];
  assign b_neg  = sgn_in & busB[WIDTH-1];

  muldiv_signfix #(.W(WIDTH)) u_mag_a (.value(busA), .neg(a_neg), .result(mag_a));
  muldiv_signfix #(.W(WIDTH)) u_mag_b (.value(busB), .neg(b_neg), .result(mag_b));

  // Multiply step: acc = {partial product upper, remaining multiplier bits}
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;

  assign mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                 + (acc_reg[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
  assign mul_acc = {mul_sum, acc_reg[WIDTH-1:1]};

  // Divide step: acc = {partial remainder, dividend bits / quotient bits}
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_acc;

  assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_reg};
  assign div_diff  = div_shift[WIDTH-1:0] - b_reg;
  assign div_acc   = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                      acc_reg[WIDTH-2:0], div_ge};

  // Sign correction; a zero divisor keeps the all-ones quotient unsigned
  logic               div_by_zero;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign div_by_zero = (b_reg == '0);

  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
    .value(acc_reg), .neg(neg_q_reg), .result(prod_fix)
  );
  muldiv_signfix #(.W(WIDTH)) u_fix_quo (
    .value(acc_reg[WIDTH-1:0]), .neg(neg_q_reg & ~div_by_zero), .result(quo_fix)
  );
  muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .value(acc_reg[2*WIDTH-1:WIDTH]), .neg(neg_r_reg), .result(rem_fix)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:       if (start) state_next = op_is_div(op_in) ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (counter_reg == LAST_STEP) state_next = S_FIX;
      S_FIX:        state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != S_IDLE);
      done_reg  <= (state_reg == S_FIX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg      <= OP_MULTU;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      counter_reg <= '0;
      acc_reg     <= '0;
      b_reg       <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg      <= op_in;
            neg_q_reg   <= a_neg ^ b_neg;
            neg_r_reg   <= a_neg;
            counter_reg <= '0;
            // Multiplier bits sit in the low half; the divisor is held in b_reg
            if (op_is_div(op_in)) begin
              acc_reg <= {{WIDTH{1'b0}}, mag_a};
              b_reg   <= mag_b;
            end else begin
              acc_reg <= {{WIDTH{1'b0}}, mag_b};
              b_reg   <= mag_a;
            end
          end else begin
            if (hi_wr) hi_reg <= wdata;
            if (lo_wr) lo_reg <= wdata;
          end
        end
        S_MUL: begin
          acc_reg     <= mul_acc;
          counter_reg <= counter_reg + CNT_W'(1);
        end
        S_DIV: begin
          acc_reg     <= div_acc;
          counter_reg <= counter_reg + CNT_W'(1);
        end
        S_FIX: begin
          if (op_is_div(op_reg)) begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative HI/LO multiply/divide unit downstream of the register file.
- Consumes the busA (rs) and busB (rt) operands and executes MULT/MULTU/DIV/DIVU over multiple cycles.
- Holds the architectural HI/LO registers; the result mux reads them for MFHI/MFLO.
- Control stalls the PC while busy is high.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each, product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- busA  input  WIDTH  rs operand (multiplicand / dividend).
- busB  input  WIDTH  rt operand (multiplier / divisor).
- hi_wr  input  1  MTHI write enable.
- lo_wr  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data (rs value).
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clocking/reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- Reset mid-operation aborts the operation and clears HI/LO; no done pulse.
- State machine: IDLE -> MUL | DIV -> FIX -> IDLE.
- IDLE, start=1 (edge E0):
  - Latch op.
  - Latch operand magnitudes: for signed ops, |busA| and |busB|; otherwise raw values.
  - Record neg_q = sign(A) xor sign(B) and neg_r = sign(A); both 0 for unsigned ops.
  - counter=0; busy=1 from E0.
- MUL: radix-2 shift-add, one multiplier bit per edge, LSB first. Runs edges E1..E32, then goes to FIX.
- DIV: restoring division, one quotient bit per edge, MSB first, 33-bit partial-remainder subtract. Runs E1..E32, then goes to FIX.
- FIX (edge E33):
  - Apply sign correction.
  - MUL: negate the 64-bit product if neg_q.
  - DIV: negate the quotient if neg_q; negate the remainder if neg_r.
  - Write {hi,lo}: HI = product[63:32] or remainder; LO = product[31:0] or quotient.
  - busy=0; done=1 for exactly the cycle after E33.
- Latency: start to HI/LO valid is 34 edges. A new start is accepted in the cycle done is high.
- Divide by zero (busB=0, either signed or unsigned): HI=busA (original value), LO=all ones. Still takes full latency; no exception.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural wrap of the magnitude path, no special case.
- start while busy: ignored.
- hi_wr/lo_wr while busy: ignored; HI/LO are untouched until FIX.
- In IDLE: hi_wr/lo_wr write wdata at the edge.
- start together with hi_wr/lo_wr in IDLE: start wins and the writes are dropped.
- hi_wr and lo_wr together: both written with wdata.
- hi/lo are register outputs with no combinational path from inputs. busy is a register output.
- Arithmetic is modulo 2^64 for the product and modulo 2^32 for the quotient/remainder. No overflow flag.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULTU, OP_MULT, OP_DIVU, OP_DIV;
  - state encoding S_IDLE, S_MUL, S_DIV, S_FIX;
  - WIDTH default.
- One natural sub-module: muldiv_signfix, a combinational magnitude/negate helper used at capture and in FIX.
- The FSM, datapath registers and counter stay in muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy for 34 cycles; done pulses once; HI=0xFFFFFFFE, LO=0x00000001.
- MULT busA=0xFFFFFFFD (-3), busB=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIVU 100/7 -> LO=0x0000000E, HI=0x00000002.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> HI=5, LO=0xFFFFFFFF.
- MTHI 0x1234 in IDLE -> hi=0x1234 next cycle.
- MTLO and start asserted during busy -> no effect.
- rst_n low at cycle 10 of a MULT -> hi=lo=0, busy=0, no done pulse.
- After reset release, a fresh MULTU 3×4 -> LO=12.
